// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: token encodings, controller FSM states and
// the board cell addressing rule used by the drop controller.
package connect4_pkg;

  localparam logic [1:0] EMPTY    = 2'b00;
  localparam logic [1:0] PLAYER_1 = 2'b01;
  localparam logic [1:0] PLAYER_2 = 2'b10;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2,
    REJ   = 2'd3
  } state_t;

  // Row 0 is the top row; cells are laid out row-major.
  function automatic int cell_addr(input int col, input int row, input int cols = 7);
    return col + cols * row;
  endfunction

endpackage

// File: rtl/drop_controller_col_height_file.sv
// Per-column fill height counters with saturating increment and registered
// column-full flags.
module col_height_file #(
  parameter int COLS = 7,
  parameter int ROWS = 6,
  localparam int COL_W = $clog2(COLS),
  localparam int HW = $clog2(ROWS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic [COL_W-1:0] i_inc_col,
  input  logic [COL_W-1:0] i_rd_col,
  output logic [HW-1:0]    o_rd_height,
  output logic [COLS-1:0]  o_col_full
);

  logic [HW-1:0]   r_h [COLS];
  logic [COLS-1:0] r_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) r_h[c] <= '0;
      r_full <= '0;
    end else if (i_inc && (int'(i_inc_col) < COLS)) begin
      if (int'(r_h[i_inc_col]) < ROWS) begin
        r_h[i_inc_col]    <= r_h[i_inc_col] + HW'(1);
        // Flag follows the new height in the same edge so it is valid right after the write.
        r_full[i_inc_col] <= (int'(r_h[i_inc_col]) + 1 == ROWS);
      end
    end
  end

  assign o_rd_height = (int'(i_rd_col) < COLS) ? r_h[i_rd_col] : '0;
  assign o_col_full  = r_full;

endmodule

// File: rtl/drop_controller.sv
// Connect-4 piece-drop controller: clears board RAM after reset, then accepts
// one drop per handshake, writes the mover's token and alternates players.
module drop_controller
  import connect4_pkg::*;
#(
  parameter int COLS = 7,
  parameter int ROWS = 6,
  parameter int CELL_W = 2,
  parameter int ADDR_W = $clog2(COLS * ROWS),
  parameter int COL_W = $clog2(COLS)
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    drop_valid,
  input  logic [COL_W-1:0]        drop_col,
  output logic                    drop_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [CELL_W-1:0]       mem_data,
  output logic                    mem_wren,
  output logic                    done,
  output logic [$clog2(ROWS)-1:0] done_row,
  output logic [COL_W-1:0]        done_col,
  output logic                    reject,
  output logic [CELL_W-1:0]       current_player,
  output logic [COLS-1:0]         col_full,
  output logic                    board_full
);

  localparam int N    = COLS * ROWS;
  localparam int HW   = $clog2(ROWS + 1);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(N + 1);

  state_t            r_state, w_next;
  logic [CW-1:0]     r_clr, r_count;
  logic [CELL_W-1:0] r_player;
  logic              r_board_full;
  logic              r_ready, r_wren, r_done, r_rej;
  logic [ADDR_W-1:0] r_addr;
  logic [CELL_W-1:0] r_data;
  logic [RW-1:0]     r_row;
  logic [COL_W-1:0]  r_dcol;

  logic              w_ready, w_wren, w_done, w_rej, w_clr_inc, w_inc;
  logic [ADDR_W-1:0] w_addr;
  logic [CELL_W-1:0] w_data;
  logic [RW-1:0]     w_row;
  logic [COL_W-1:0]  w_dcol;
  logic [HW-1:0]     w_h;
  logic [COLS-1:0]   w_col_full;
  logic              w_col_ok;
  logic [COL_W-1:0]  w_sel;

  col_height_file #(.COLS(COLS), .ROWS(ROWS)) u_heights (
    .clk        (CLOCK_50),
    .rst        (reset),
    .i_inc      (w_inc),
    .i_inc_col  (r_dcol),
    .i_rd_col   (drop_col),
    .o_rd_height(w_h),
    .o_col_full (w_col_full)
  );

  assign w_col_ok = (int'(drop_col) < COLS);
  assign w_sel    = w_col_ok ? drop_col : '0;

  // Outputs are registered: next-cycle values are decided here from the current state.
  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_wren    = 1'b0;
    w_done    = 1'b0;
    w_rej     = 1'b0;
    w_clr_inc = 1'b0;
    w_inc     = 1'b0;
    w_addr    = r_addr;
    w_data    = r_data;
    w_row     = r_row;
    w_dcol    = r_dcol;
    case (r_state)
      CLEAR: begin
        if (r_clr == CW'(N)) begin
          w_next  = IDLE;
          w_ready = 1'b1;
        end else begin
          w_wren    = 1'b1;
          w_addr    = ADDR_W'(r_clr);
          w_data    = CELL_W'(EMPTY);
          w_clr_inc = 1'b1;
        end
      end
      IDLE: begin
        w_ready = 1'b1;
        if (drop_valid && r_ready) begin
          w_ready = 1'b0;
          if (!w_col_ok || w_col_full[w_sel] || r_board_full) begin
            w_next = REJ;
            w_rej  = 1'b1;
          end else begin
            w_next = WRITE;
            w_wren = 1'b1;
            w_done = 1'b1;
            w_addr = ADDR_W'(cell_addr(int'(drop_col), ROWS - 1 - int'(w_h), COLS));
            w_data = r_player;
            w_row  = RW'(ROWS - 1 - int'(w_h));
            w_dcol = drop_col;
          end
        end
      end
      WRITE: begin
        w_next  = IDLE;
        w_ready = 1'b1;
        w_inc   = 1'b1;
      end
      REJ: begin
        w_next  = IDLE;
        w_ready = 1'b1;
      end
      default: w_next = CLEAR;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state      <= CLEAR;
      r_clr        <= '0;
      r_count      <= '0;
      r_player     <= CELL_W'(PLAYER_1);
      r_board_full <= 1'b0;
      r_ready      <= 1'b0;
      r_wren       <= 1'b0;
      r_done       <= 1'b0;
      r_rej        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_row        <= '0;
      r_dcol       <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_ready;
      r_wren  <= w_wren;
      r_done  <= w_done;
      r_rej   <= w_rej;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_row   <= w_row;
      r_dcol  <= w_dcol;
      if (w_clr_inc) r_clr <= r_clr + CW'(1);
      if (w_inc) begin
        r_count      <= r_count + CW'(1);
        r_board_full <= (int'(r_count) + 1 == N);
        r_player     <= (r_player == CELL_W'(PLAYER_1)) ? CELL_W'(PLAYER_2) : CELL_W'(PLAYER_1);
      end
    end
  end

  assign drop_ready     = r_ready;
  assign mem_wren       = r_wren;
  assign mem_addr       = r_addr;
  assign mem_data       = r_data;
  assign done           = r_done;
  assign done_row       = r_row;
  assign done_col       = r_dcol;
  assign reject         = r_rej;
  assign current_player = r_player;
  assign col_full       = w_col_full;
  assign board_full     = r_board_full;

endmodule

// File: tb/tb_drop_controller.sv
// Directed bench for drop_controller on the default 7x6 board.
module tb_drop_controller;

  logic       CLOCK_50;
  logic       reset;
  logic       drop_valid;
  logic [2:0] drop_col;
  logic       drop_ready;
  logic [5:0] mem_addr;
  logic [1:0] mem_data;
  logic       mem_wren;
  logic       done;
  logic [2:0] done_row;
  logic [2:0] done_col;
  logic       reject;
  logic [1:0] current_player;
  logic [6:0] col_full;
  logic       board_full;

  int checks   = 0;
  int failures = 0;
  int heights [7];
  int moves;

  drop_controller dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .drop_valid    (drop_valid),
    .drop_col      (drop_col),
    .drop_ready    (drop_ready),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_wren      (mem_wren),
    .done          (done),
    .done_row      (done_row),
    .done_col      (done_col),
    .reject        (reject),
    .current_player(current_player),
    .col_full      (col_full),
    .board_full    (board_full)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request for one cycle; returns in the cycle after the handshake.
  task automatic req(input int col);
    drop_valid = 1'b1;
    drop_col   = 3'(col);
    step();
    drop_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100 && !drop_ready; i++) step();
    chk("ready_wait", 32'(drop_ready), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    drop_valid = 1'b0;
    drop_col   = '0;
    step();
    // Reset cycle R
    chk("rst_ready", 32'(drop_ready), 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);
    chk("rst_player", 32'(current_player), 32'd1);
    chk("rst_colfull", 32'(col_full), 32'd0);
    chk("rst_boardfull", 32'(board_full), 32'd0);
    chk("rst_done_row", 32'(done_row), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 42; i++) begin
      step();
      chk("clr_wren", 32'(mem_wren), 32'd1);
      chk("clr_addr", 32'(mem_addr), 32'(i));
      chk("clr_data", 32'(mem_data), 32'd0);
      chk("clr_ready_low", 32'(drop_ready), 32'd0);
    end
    step();
    chk("clr_ready_r43", 32'(drop_ready), 32'd1);
    chk("clr_wren_end", 32'(mem_wren), 32'd0);

    // First drops into column 3
    req(3);
    chk("d1_wren", 32'(mem_wren), 32'd1);
    chk("d1_addr", 32'(mem_addr), 32'd38);
    chk("d1_data", 32'(mem_data), 32'd1);
    chk("d1_done", 32'(done), 32'd1);
    chk("d1_row", 32'(done_row), 32'd5);
    chk("d1_col", 32'(done_col), 32'd3);
    chk("d1_ready_low", 32'(drop_ready), 32'd0);
    step();
    chk("d1_ready_back", 32'(drop_ready), 32'd1);
    chk("d1_done_pulse", 32'(done), 32'd0);
    chk("d1_wren_off", 32'(mem_wren), 32'd0);
    chk("d1_player", 32'(current_player), 32'd2);
    req(3);
    chk("d2_addr", 32'(mem_addr), 32'd31);
    chk("d2_data", 32'(mem_data), 32'd2);
    chk("d2_row", 32'(done_row), 32'd4);
    step();
    chk("d2_player", 32'(current_player), 32'd1);

    // Fill column 0
    for (int k = 0; k < 6; k++) begin
      req(0);
      chk("c0_wren", 32'(mem_wren), 32'd1);
      chk("c0_addr", 32'(mem_addr), 32'(35 - 7 * k));
      step();
    end
    chk("c0_full", 32'(col_full), 32'h01);
    chk("c0_player", 32'(current_player), 32'd1);
    req(0);
    chk("c0_rej_pulse", 32'(reject), 32'd1);
    chk("c0_rej_wren", 32'(mem_wren), 32'd0);
    chk("c0_rej_done", 32'(done), 32'd0);
    step();
    chk("c0_rej_player", 32'(current_player), 32'd1);
    chk("c0_rej_clear", 32'(reject), 32'd0);

    // Out-of-range column
    req(7);
    chk("inv_reject", 32'(reject), 32'd1);
    chk("inv_wren", 32'(mem_wren), 32'd0);
    chk("inv_ready_low", 32'(drop_ready), 32'd0);
    step();
    chk("inv_ready_back", 32'(drop_ready), 32'd1);
    chk("inv_player", 32'(current_player), 32'd1);

    // Fill the rest of the board
    heights = '{6, 0, 0, 2, 0, 0, 0};
    moves   = 8;
    for (int c = 1; c < 7; c++) begin
      while (heights[c] < 6) begin
        req(c);
        chk("bf_addr", 32'(mem_addr), 32'(c + 7 * (5 - heights[c])));
        chk("bf_data", 32'(mem_data), (moves % 2 == 0) ? 32'd1 : 32'd2);
        heights[c]++;
        moves++;
        step();
        chk("bf_board_full", 32'(board_full), (moves == 42) ? 32'd1 : 32'd0);
      end
    end
    chk("bf_colfull", 32'(col_full), 32'h7F);
    chk("bf_player", 32'(current_player), 32'd1);
    req(2);
    chk("bf_reject", 32'(reject), 32'd1);
    chk("bf_rej_wren", 32'(mem_wren), 32'd0);
    step();

    // Reset during WRITE
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_ready();
    chk("r2_colfull", 32'(col_full), 32'd0);
    req(4);
    chk("r2_addr", 32'(mem_addr), 32'd39);
    chk("r2_wren", 32'(mem_wren), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rw_wren", 32'(mem_wren), 32'd0);
    chk("rw_done", 32'(done), 32'd0);
    chk("rw_reject", 32'(reject), 32'd0);
    chk("rw_player", 32'(current_player), 32'd1);
    step();
    chk("rw_sweep_wren", 32'(mem_wren), 32'd1);
    chk("rw_sweep_addr", 32'(mem_addr), 32'd0);
    wait_ready();
    chk("rw_colfull", 32'(col_full), 32'd0);
    chk("rw_boardfull", 32'(board_full), 32'd0);
    chk("rw_player2", 32'(current_player), 32'd1);
    req(4);
    chk("rw_addr", 32'(mem_addr), 32'd39);
    chk("rw_row", 32'(done_row), 32'd5);
    chk("rw_data", 32'(mem_data), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
